// File: rtl/input_conditioner_pkg.sv
// Shared definitions for the CORDIC input conditioner: FSM encoding,
// Q2.20 saturation limits, IEEE-754 single field layout and float halving.
package input_conditioner_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    LATCH = 3'b001,
    CONV  = 3'b010,
    WAIT  = 3'b011,
    DONE  = 3'b111
  } state_t;

  // Float and fixed-point widths the converter and halving logic are built for
  localparam int FLT_W    = 32;
  localparam int FIX_W    = 22;
  localparam int FIX_FRAC = 20;

  // Q2.20 rails used when |x| >= 2 or the operand is Inf/NaN
  localparam logic [FIX_W-1:0] FIX_MAX = 22'h1FFFFF;
  localparam logic [FIX_W-1:0] FIX_MIN = 22'h200000;

  // IEEE-754 single-precision field layout
  localparam int SIGN_POS = 31;
  localparam int EXP_LSB  = 23;
  localparam int EXP_W    = 8;
  localparam int MAN_W    = 23;
  localparam int EXP_BIAS = 127;

  localparam logic [EXP_W-1:0] EXP_SPECIAL = 8'hFF;

  // x/2 by exponent decrement; tiny inputs flush to a signed zero and
  // Inf/NaN pass through untouched.
  function automatic logic [FLT_W-1:0] half_float(input logic [FLT_W-1:0] x);
    logic [EXP_W-1:0] e;
    e = x[EXP_LSB +: EXP_W];
    if (e == EXP_SPECIAL) begin
      half_float = x;
    end else if (e <= 8'd1) begin
      half_float = {x[SIGN_POS], {(FLT_W-1){1'b0}}};
    end else begin
      half_float = {x[SIGN_POS], e - 8'd1, x[MAN_W-1:0]};
    end
  endfunction

endpackage

// File: rtl/input_conditioner_float_to_fixed.sv
// Combinational IEEE-754 single -> signed Q2.20 converter with saturation flag.
module float_to_fixed
  import input_conditioner_pkg::*;
(
  input  logic [FLT_W-1:0] flt,
  output logic [FIX_W-1:0] fix,
  output logic             sat
);

  // Exponent at which the 24-bit significand lands exactly on Q2.20 (130)
  localparam int SHIFT_ZERO = EXP_BIAS + MAN_W - FIX_FRAC;
  // Smallest exponent that reaches the |x| >= 2 range
  localparam logic [EXP_W-1:0] EXP_SAT = EXP_W'(EXP_BIAS + 1);
  // At or below this exponent the right shift is >= 24 and the result is 0;
  // it also excludes exponent 0 (zero and denormals)
  localparam logic [EXP_W-1:0] EXP_MIN = EXP_W'(SHIFT_ZERO - (MAN_W + 1));

  logic             sign;
  logic [EXP_W-1:0] exp_f;
  logic [MAN_W-1:0] man;
  logic [EXP_W-1:0] rshift;
  logic [FIX_W-1:0] mag;

  // Shift, negate and saturate. Every non-saturating exponent is below
  // SHIFT_ZERO, so only the right-shift path exists in hardware.
  always_comb begin
    sign   = flt[SIGN_POS];
    exp_f  = flt[EXP_LSB +: EXP_W];
    man    = flt[MAN_W-1:0];
    rshift = EXP_W'(SHIFT_ZERO) - exp_f;
    mag    = FIX_W'({1'b1, man} >> rshift);
    fix    = '0;
    sat    = 1'b0;

    if (exp_f >= EXP_SAT) begin
      if (sign) begin
        fix = FIX_MIN;
        // -2.0 exactly is representable as the negative rail
        sat = (exp_f != EXP_SAT) || (man != '0);
      end else begin
        fix = FIX_MAX;
        sat = 1'b1;
      end
    end else if (exp_f > EXP_MIN) begin
      fix = sign ? (~mag + FIX_W'(1)) : mag;
    end
  end

endmodule

// File: rtl/mult.sv
// Behavioural model of the float multiplier core: IEEE-754 single product,
// round-to-nearest-even, denormals flushed to zero, LATENCY clock-enabled
// pipeline stages with no reset (the vendor core has none either).
module mult #(
  parameter int LATENCY = 5
) (
  input  logic        clk,
  input  logic        clk_en,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result
);

  logic               sign_p;
  logic [7:0]         exp_a, exp_b;
  logic [23:0]        sig_a, sig_b;
  logic [47:0]        prod;
  logic [22:0]        frac;
  logic               guard, sticky, round_up;
  logic [23:0]        frac_rnd;
  logic signed [9:0]  exp_p;
  logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [31:0]        comb_res;
  logic [31:0]        pipe [LATENCY];

  // Single-cycle product; the pipeline below supplies the core's latency
  always_comb begin
    exp_a  = a[30:23];
    exp_b  = b[30:23];
    sig_a  = {1'b1, a[22:0]};
    sig_b  = {1'b1, b[22:0]};
    sign_p = a[31] ^ b[31];
    a_zero = (exp_a == 8'd0);
    b_zero = (exp_b == 8'd0);
    a_inf  = (exp_a == 8'hFF) && (a[22:0] == 23'd0);
    b_inf  = (exp_b == 8'hFF) && (b[22:0] == 23'd0);
    a_nan  = (exp_a == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (exp_b == 8'hFF) && (b[22:0] != 23'd0);

    prod  = {24'd0, sig_a} * {24'd0, sig_b};
    exp_p = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - 10'sd127;

    // Product of two [1,2) significands lies in [1,4): normalise by one bit
    if (prod[47]) begin
      frac   = prod[46:24];
      guard  = prod[23];
      sticky = |prod[22:0];
      exp_p  = exp_p + 10'sd1;
    end else begin
      frac   = prod[45:23];
      guard  = prod[22];
      sticky = |prod[21:0];
    end

    round_up = guard & (sticky | frac[0]);
    frac_rnd = {1'b0, frac} + {23'd0, round_up};
    // Rounding carry out of the fraction bumps the exponent; fraction is then 0
    if (frac_rnd[23]) begin
      exp_p = exp_p + 10'sd1;
    end

    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      comb_res = 32'h7FC0_0000;
    end else if (a_inf || b_inf) begin
      comb_res = {sign_p, 8'hFF, 23'd0};
    end else if (a_zero || b_zero) begin
      comb_res = {sign_p, 31'd0};
    end else if (exp_p >= 10'sd255) begin
      comb_res = {sign_p, 8'hFF, 23'd0};
    end else if (exp_p <= 10'sd0) begin
      comb_res = {sign_p, 31'd0};
    end else begin
      comb_res = {sign_p, exp_p[7:0], frac_rnd[22:0]};
    end
  end

  // Delay line that freezes together with the rest of the pipeline
  always_ff @(posedge clk) begin
    if (clk_en) begin
      pipe[0] <= comb_res;
      for (int i = 1; i < LATENCY; i++) begin
        pipe[i] <= pipe[i-1];
      end
    end
  end

  assign result = pipe[LATENCY-1];

endmodule

// File: rtl/input_conditioner.sv
// CORDIC front end: latches an operand pair, converts each to Q2.20,
// halves and squares both, then pulses done with all six results held.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int FLT_DATA_WIDTH    = 32,
  parameter int CORDIC_DATA_WIDTH = 22,
  parameter int MUL_LATENCY       = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clk_en,
  input  logic                         start,
  input  logic [FLT_DATA_WIDTH-1:0]    x_one,
  input  logic [FLT_DATA_WIDTH-1:0]    x_two,
  output logic                         done,
  output logic                         working,
  output logic [CORDIC_DATA_WIDTH-1:0] out_one,
  output logic [CORDIC_DATA_WIDTH-1:0] out_two,
  output logic [FLT_DATA_WIDTH-1:0]    half_out_one,
  output logic [FLT_DATA_WIDTH-1:0]    half_out_two,
  output logic [FLT_DATA_WIDTH-1:0]    square_out_one,
  output logic [FLT_DATA_WIDTH-1:0]    square_out_two,
  output logic [1:0]                   sat
);

  localparam int CNT_W = $clog2(MUL_LATENCY + 1);

  state_t                         state_reg, state_next;
  logic [CNT_W-1:0]               cnt_reg;
  logic                           cnt_last;
  logic [FLT_DATA_WIDTH-1:0]      x_one_reg, x_two_reg;
  logic [CORDIC_DATA_WIDTH-1:0]   out_one_reg, out_two_reg;
  logic [FLT_DATA_WIDTH-1:0]      half_one_reg, half_two_reg;
  logic [FLT_DATA_WIDTH-1:0]      sq_one_reg, sq_two_reg;
  logic [1:0]                     sat_reg;
  logic [FLT_DATA_WIDTH-1:0]      conv_in;
  logic [CORDIC_DATA_WIDTH-1:0]   conv_fix;
  logic                           conv_sat;
  logic [FLT_DATA_WIDTH-1:0]      mult_in  [2];
  logic [FLT_DATA_WIDTH-1:0]      mult_res [2];

  // Counter value 1 in WAIT means the squares emerge from the core this cycle
  assign cnt_last = (cnt_reg == CNT_W'(1));

  // State register; clk_en freezes the whole sequence
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else if (clk_en) begin
      state_reg <= state_next;
    end
  end

  // Next-state decode; start outside IDLE is simply not looked at
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = LATCH;
      LATCH:   state_next = CONV;
      CONV:    state_next = WAIT;
      WAIT:    if (cnt_last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Capture the operand pair on an accepted start
  always_ff @(posedge clk) begin
    if (!rst) begin
      x_one_reg <= '0;
      x_two_reg <= '0;
    end else if (clk_en && state_reg == IDLE && start) begin
      x_one_reg <= x_one;
      x_two_reg <= x_two;
    end
  end

  // Square latency counter: loaded leaving LATCH, counts down through CONV/WAIT
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else if (clk_en) begin
      if (state_reg == LATCH) begin
        cnt_reg <= CNT_W'(MUL_LATENCY);
      end else if ((state_reg == CONV || state_reg == WAIT) && cnt_reg != '0) begin
        cnt_reg <= cnt_reg - CNT_W'(1);
      end
    end
  end

  // One converter serves both operands: x_one in LATCH, x_two in CONV
  assign conv_in = (state_reg == CONV) ? x_two_reg : x_one_reg;

  float_to_fixed u_float_to_fixed (
    .flt (conv_in),
    .fix (conv_fix),
    .sat (conv_sat)
  );

  // Register conversion results and halves as each operand is processed
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_one_reg  <= '0;
      out_two_reg  <= '0;
      half_one_reg <= '0;
      half_two_reg <= '0;
      sat_reg      <= '0;
    end else if (clk_en) begin
      if (state_reg == LATCH) begin
        out_one_reg  <= conv_fix;
        sat_reg[0]   <= conv_sat;
        half_one_reg <= half_float(x_one_reg);
        half_two_reg <= half_float(x_two_reg);
      end else if (state_reg == CONV) begin
        out_two_reg  <= conv_fix;
        sat_reg[1]   <= conv_sat;
      end
    end
  end

  // Each multiplier squares its own operand straight from the latched register
  assign mult_in[0] = x_one_reg;
  assign mult_in[1] = x_two_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_square
      mult #(
        .LATENCY (MUL_LATENCY)
      ) u_mult (
        .clk    (clk),
        .clk_en (clk_en),
        .a      (mult_in[gi]),
        .b      (mult_in[gi]),
        .result (mult_res[gi])
      );
    end
  endgenerate

  // Capture squares as the counter expires on the way into DONE
  always_ff @(posedge clk) begin
    if (!rst) begin
      sq_one_reg <= '0;
      sq_two_reg <= '0;
    end else if (clk_en && state_reg == WAIT && cnt_last) begin
      sq_one_reg <= mult_res[0];
      sq_two_reg <= mult_res[1];
    end
  end

  assign done           = (state_reg == DONE);
  assign working        = (state_reg != IDLE);
  assign out_one        = out_one_reg;
  assign out_two        = out_two_reg;
  assign half_out_one   = half_one_reg;
  assign half_out_two   = half_two_reg;
  assign square_out_one = sq_one_reg;
  assign square_out_two = sq_two_reg;
  assign sat            = sat_reg;

endmodule
